// File: rtl/axi4s_pkt_len_check.sv
// axi4s_pkt_len_check: AXI4-Stream packet-length policer.
// Counts words per packet, truncates packets longer than MAX_WORDS with a
// forced tlast (discarding the rest of the input packet), and raises o_terror
// on the final output word of any short or oversize packet.
// Optional feature: define AXI4S_PKT_LEN_CHECK_STATS_EN to build the
// saturating err_count statistics counter; otherwise err_count reads zero.
module axi4s_pkt_len_check #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_WORDS  = 1024,
    parameter int MIN_WORDS  = 1,
    parameter int CNT_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    input  logic                  i_tlast,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic                  o_tlast,
    output logic                  o_terror,
    output logic [15:0]           err_count
);

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_TRUNC = 1'b1
    } state_t;

    // Length limits widened by one bit so cnt+1 never overflows the compare
    localparam logic [CNT_W:0] MIN_LEN = (CNT_W + 1)'(MIN_WORDS);
    localparam logic [CNT_W:0] MAX_LEN = (CNT_W + 1)'(MAX_WORDS);
    localparam logic [CNT_W:0] ONE     = (CNT_W + 1)'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             out_free;
    logic             accept;
    logic             pass_load;
    logic             hit_max;
    logic             too_short;
    logic             err_word;

    // Output register can take a new word when empty or being drained
    assign out_free  = !o_tvalid || o_tready;
    // In TRUNC the discarded tail drains regardless of downstream backpressure
    assign i_tready  = (state == ST_TRUNC) || out_free;
    assign accept    = i_tvalid && i_tready;
    assign pass_load = accept && (state == ST_PASS);
    assign cnt_inc   = {1'b0, cnt} + ONE;
    assign hit_max   = (cnt_inc == MAX_LEN);
    assign too_short = (cnt_inc < MIN_LEN);
    // A real tlast is bad only when short; a non-last word hitting the limit is a forced truncation
    assign err_word  = i_tlast ? too_short : hit_max;

    // Policing FSM, word counter and registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_PASS;
            cnt      <= '0;
            o_tdata  <= '0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_terror <= 1'b0;
        end else if (clear) begin
            state    <= ST_PASS;
            cnt      <= '0;
            o_tvalid <= 1'b0;
        end else begin
            case (state)
                ST_PASS: begin
                    if (pass_load) begin
                        o_tvalid <= 1'b1;
                        o_tdata  <= i_tdata;
                        o_terror <= err_word;
                        if (i_tlast) begin
                            o_tlast <= 1'b1;
                            cnt     <= '0;
                        end else if (hit_max) begin
                            o_tlast <= 1'b1;
                            cnt     <= '0;
                            state   <= ST_TRUNC;
                        end else begin
                            o_tlast <= 1'b0;
                            cnt     <= cnt_inc[CNT_W-1:0];
                        end
                    end else if (o_tready) begin
                        o_tvalid <= 1'b0;
                    end
                end
                ST_TRUNC: begin
                    if (o_tready) begin
                        o_tvalid <= 1'b0;
                    end
                    if (accept && i_tlast) begin
                        state <= ST_PASS;
                    end
                end
                default: begin
                    state <= ST_PASS;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef AXI4S_PKT_LEN_CHECK_STATS_EN
    logic [15:0] err_cnt_q;

    // Count flagged words as they enter the output register, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (clear) begin
            err_cnt_q <= '0;
        end else if (pass_load && err_word && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_axi4s_pkt_len_check.sv
// tb_axi4s_pkt_len_check: self-checking bench for axi4s_pkt_len_check
// with MAX_WORDS=8, MIN_WORDS=2. Expected output words come from a
// packet-level model: each packet of length L yields its first min(L,8)
// words, tlast on the last of those, error when L<2 or L>8.
module tb_axi4s_pkt_len_check;

    localparam int DW   = 16;
    localparam int MAXW = 8;
    localparam int MINW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [DW-1:0] i_tdata;
    logic          i_tvalid;
    logic          i_tready;
    logic          i_tlast;
    logic [DW-1:0] o_tdata;
    logic          o_tvalid;
    logic          o_tready;
    logic          o_tlast;
    logic          o_terror;
    logic [15:0]   err_count;

    int checks = 0;
    int passed = 0;
    int bad_pkts = 0;
    bit rand_ready = 1'b0;

    // expected output words: {tdata, tlast, terror}
    logic [DW+1:0] exp_q[$];

    logic          stall_prev = 1'b0;
    logic [DW+2:0] held_prev;

    axi4s_pkt_len_check #(
        .DATA_WIDTH(DW),
        .MAX_WORDS (MAXW),
        .MIN_WORDS (MINW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .i_tlast  (i_tlast),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tlast  (o_tlast),
        .o_terror (o_terror),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] exp_err_count();
`ifdef AXI4S_PKT_LEN_CHECK_STATS_EN
        return (bad_pkts > 65535) ? 16'hFFFF : 16'(bad_pkts);
`else
        return 16'h0000;
`endif
    endfunction

    // Present one word and wait (bounded) for its handshake; returns #1 after the accepting edge
    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit must_ready);
        int waited;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = last;
        waited   = 0;
        @(negedge clk);
        if (must_ready) check_output("trunc_tready", 64'(i_tready), 64'd1);
        while (!i_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!i_tready) begin
            check_output("handshake_timeout", 64'd0, 64'd1);
            i_tvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    // Drive one packet of len words, predicting its output at packet level
    task automatic apply_stimulus(input int len);
        logic [DW-1:0] d;
        bit bad;
        bad = (len < MINW) || (len > MAXW);
        for (int w = 1; w <= len; w++) begin
            d = DW'($urandom);
            if (w <= MAXW) begin
                logic e_last;
                e_last = (w == len) || (w == MAXW);
                exp_q.push_back({d, e_last, e_last && bad});
            end
            send_word(d, (w == len), (w > MAXW));
        end
        if (bad) bad_pkts++;
        check_output($sformatf("err_count_len%0d", len), 64'(err_count), 64'(exp_err_count()));
    endtask

    // Bounded wait for all predicted words to leave the DUT
    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check_output("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: score transfers and check output stability while stalled
    always @(negedge clk) begin
        logic [DW+1:0] e;
        if (stall_prev && rst_n && !clear)
            check_output("stall_stable", 64'({o_tvalid, o_tdata, o_tlast, o_terror}), 64'(held_prev));
        if (rst_n && !clear && o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_word", 64'({o_tdata, o_tlast, o_terror}), 64'h0);
            end else begin
                e = exp_q.pop_front();
                check_output("out_word", 64'({o_tdata, o_tlast, o_terror}), 64'(e));
            end
        end
        stall_prev = o_tvalid && !o_tready && rst_n && !clear;
        held_prev  = {o_tvalid, o_tdata, o_tlast, o_terror};
    end

    // Random downstream backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) o_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_o_tdata", 64'(o_tdata), 64'd0);
        check_output("rst_o_tlast", 64'(o_tlast), 64'd0);
        check_output("rst_o_terror", 64'(o_terror), 64'd0);
        check_output("rst_err_count", 64'(err_count), 64'd0);
        check_output("rst_i_tready", 64'(i_tready), 64'd1);

        $display("[TB] exact-max packet, oversize packet, short packet");
        apply_stimulus(8);
        drain();
        apply_stimulus(11);
        apply_stimulus(3);
        drain();
        apply_stimulus(1);
        drain();

        $display("[TB] random backpressure with mixed packet lengths");
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) apply_stimulus($urandom_range(1, 14));
        drain();
        rand_ready = 1'b0;
        o_tready   = 1'b1;
        apply_stimulus(1);
        drain();

        $display("[TB] clear mid-packet");
        for (int w = 1; w <= 4; w++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            if (w < 4) exp_q.push_back({d, 1'b0, 1'b0});
            send_word(d, 1'b0, 1'b0);
        end
        o_tready = 1'b0;
        check_output("pre_clear_tvalid", 64'(o_tvalid), 64'd1);
        i_tvalid = 1'b1;
        i_tdata  = DW'($urandom);
        i_tlast  = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        bad_pkts = 0;
        check_output("clear_o_tvalid", 64'(o_tvalid), 64'd0);
        check_output("clear_err_count", 64'(err_count), 64'd0);
        o_tready = 1'b1;
        apply_stimulus(8);
        drain();

        $display("[TB] reset during truncation");
        for (int w = 1; w <= 8; w++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            exp_q.push_back({d, (w == 8), (w == 8)});
            send_word(d, 1'b0, 1'b0);
        end
        o_tready = 1'b0;
        send_word(DW'($urandom), 1'b0, 1'b1);
        send_word(DW'($urandom), 1'b0, 1'b1);
        check_output("trunc_pending", 64'({o_tvalid, o_tlast, o_terror}), 64'h7);
        i_tvalid = 1'b1;
        i_tdata  = DW'($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        bad_pkts = 0;
        check_output("async_rst_outputs", 64'({o_tvalid, o_tdata, o_tlast, o_terror}), 64'h0);
        check_output("async_rst_err_count", 64'(err_count), 64'd0);
        check_output("async_rst_i_tready", 64'(i_tready), 64'd1);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        apply_stimulus(3);
        apply_stimulus(5);
        drain();

`ifdef AXI4S_PKT_LEN_CHECK_STATS_EN
        $display("[TB] err_count saturation");
        for (int p = 0; p < 65536; p++) apply_stimulus(1);
        drain();
        check_output("err_count_saturated", 64'(err_count), 64'hFFFF);
`else
        apply_stimulus(1);
        drain();
        check_output("err_count_disabled", 64'(err_count), 64'h0);
`endif

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
